// File: rtl/arcade_input_pkg.sv
// Shared constants and decode helpers for the arcade player-input front end.
//  - PS/2 set-2 scan codes used by the P1/P2 keyboard maps
//  - joystick word bit indices
//  - hps_io download index that carries the MRA DIP bytes
//  - key_set_t: one player's keyboard-driven controls, plus the per-player
//    code decoders that return which of those controls a scan code hits
package arcade_input_pkg;

    // P1 keyboard map
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_CTRL  = 8'h14;
    localparam logic [7:0] KEY_ALT   = 8'h11;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_SHIFT = 8'h12;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_F1    = 8'h05;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_F3    = 8'h04;

    // P2 keyboard map
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_G     = 8'h34;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_Q     = 8'h15;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_F2    = 8'h06;
    localparam logic [7:0] KEY_6     = 8'h36;

    // Joystick word layout; start and coin follow the last action button
    localparam int unsigned JB_R    = 0;
    localparam int unsigned JB_L    = 1;
    localparam int unsigned JB_D    = 2;
    localparam int unsigned JB_U    = 3;
    localparam int unsigned JB_BTN0 = 4;

    localparam logic [7:0] IOCTL_DIP = 8'd254;

    // dir uses the joystick order: [3]U [2]D [1]L [0]R
    typedef struct packed {
        logic [3:0] dir;
        logic [3:0] btn;
        logic       start;
        logic       coin;
    } key_set_t;

    localparam int unsigned KEY_SET_W = $bits(key_set_t);

    // Arrow keys are accepted with or without the E0 prefix so the keypad
    // (non-extended) and cursor block (extended) both steer.
    function automatic logic code_is(input logic [8:0] code, input logic [7:0] want,
                                     input logic any_ext);
        return (code[7:0] == want) && (any_ext || !code[8]);
    endfunction

    function automatic key_set_t p1_hits(input logic [8:0] code);
        key_set_t h;
        h           = '0;
        h.dir[JB_U] = code_is(code, KEY_UP,    1'b1);
        h.dir[JB_D] = code_is(code, KEY_DOWN,  1'b1);
        h.dir[JB_L] = code_is(code, KEY_LEFT,  1'b1);
        h.dir[JB_R] = code_is(code, KEY_RIGHT, 1'b1);
        h.btn[0]    = code_is(code, KEY_CTRL,  1'b0);
        h.btn[1]    = code_is(code, KEY_ALT,   1'b0);
        h.btn[2]    = code_is(code, KEY_SPACE, 1'b0);
        h.btn[3]    = code_is(code, KEY_SHIFT, 1'b0);
        h.start     = code_is(code, KEY_1, 1'b0) | code_is(code, KEY_F1, 1'b0);
        h.coin      = code_is(code, KEY_5, 1'b0) | code_is(code, KEY_F3, 1'b0);
        return h;
    endfunction

    function automatic key_set_t p2_hits(input logic [8:0] code);
        key_set_t h;
        h           = '0;
        h.dir[JB_U] = code_is(code, KEY_R, 1'b0);
        h.dir[JB_D] = code_is(code, KEY_F, 1'b0);
        h.dir[JB_L] = code_is(code, KEY_D, 1'b0);
        h.dir[JB_R] = code_is(code, KEY_G, 1'b0);
        h.btn[0]    = code_is(code, KEY_A, 1'b0);
        h.btn[1]    = code_is(code, KEY_S, 1'b0);
        h.btn[2]    = code_is(code, KEY_Q, 1'b0);
        h.btn[3]    = code_is(code, KEY_W, 1'b0);
        h.start     = code_is(code, KEY_2, 1'b0) | code_is(code, KEY_F2, 1'b0);
        h.coin      = code_is(code, KEY_6, 1'b0);
        return h;
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Coin pulse stretcher: guarantees the coin line stays high for a minimum
// time so cores that poll coin slowly never miss a short key tap.
// Ports:
//  CLK    in   system clock
//  RESET  in   synchronous, active-high; clears counter and output
//  raw    in   unstretched coin (key OR joystick)
//  out    out  registered raw | (hold counter != 0)
module coin_stretch #(
    parameter int unsigned HOLD = 200000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic out
);

    if (HOLD == 0) begin : g_passthru
        logic out_q;

        always_ff @(posedge CLK) begin
            if (RESET) out_q <= 1'b0;
            else       out_q <= raw;
        end

        assign out = out_q;
    end else begin : g_stretch
        localparam int unsigned CW = $clog2(HOLD + 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          raw_q;
        logic          out_q, out_d;

        // A rising edge reloads the full hold even if a previous hold is still
        // running; otherwise count down and park at zero.
        always_comb begin
            cnt_d = cnt_q;
            if (raw && !raw_q)      cnt_d = CW'(HOLD);
            else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
            out_d = raw | (cnt_q != '0);
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                cnt_q <= '0;
                raw_q <= 1'b0;
                out_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                raw_q <= raw;
                out_q <= out_d;
            end
        end

        assign out = out_q;
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end between hps_io and an arcade core: decodes PS/2
// key events into P1/P2 key registers, ORs them with the hps_io joysticks,
// optionally cleans opposing directions (SOCD), stretches coin pulses and
// captures the MRA DIP bytes. All control outputs are active-high.
// Ports:
//  CLK, RESET     system clock; synchronous active-high reset
//  ps2_key        [10] toggle, [9] pressed, [8:0] code ([8] = E0 prefix)
//  joy            player n at [n*JOY_W +: JOY_W]
//  ioctl_*        hps_io download bus; index 254 carries DIP bytes
//  dir            per player {U,D,L,R}
//  btn            per player NUM_BTN action buttons
//  start, coin    per player; coin is stretched
//  dipsw          DIP bank i at [i*8 +: 8]
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned NUM_BTN     = 4,
    parameter int unsigned JOY_W       = 16,
    parameter int unsigned DIP_BANKS   = 8,
    parameter int unsigned COIN_HOLD   = 200000,
    parameter int unsigned SOCD_CLEAN  = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [10:0]                    ps2_key,
    input  logic [NUM_PLAYERS*JOY_W-1:0]   joy,
    input  logic                           ioctl_wr,
    input  logic [7:0]                     ioctl_index,
    input  logic [24:0]                    ioctl_addr,
    input  logic [7:0]                     ioctl_dout,
    output logic [NUM_PLAYERS*4-1:0]       dir,
    output logic [NUM_PLAYERS*NUM_BTN-1:0] btn,
    output logic [NUM_PLAYERS-1:0]         start,
    output logic [NUM_PLAYERS-1:0]         coin,
    output logic [DIP_BANKS*8-1:0]         dipsw
);

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("arcade_input_mapper: NUM_PLAYERS must be 1..4");
    end
    if (NUM_BTN < 1 || NUM_BTN > JOY_W - 6) begin : g_bad_btn
        $error("arcade_input_mapper: NUM_BTN must be 1..JOY_W-6");
    end
    if (DIP_BANKS < 1 || DIP_BANKS > 32) begin : g_bad_dip
        $error("arcade_input_mapper: DIP_BANKS must be 1..32");
    end

    localparam logic SOCD = (SOCD_CLEAN != 0);

    // ------------------------------------------------------------------
    // Keyboard event decode
    // ------------------------------------------------------------------
    logic           tog_q;
    logic           ev;
    key_set_t [1:0] hit;
    key_set_t [1:0] key_q, key_d;

    assign ev = ps2_key[10] ^ tog_q;

    // One event may match several maps; every matching control takes [9].
    always_comb begin
        hit[0] = p1_hits(ps2_key[8:0]);
        hit[1] = p2_hits(ps2_key[8:0]);
        key_d  = key_q;
        if (ev) begin
            for (int unsigned p = 0; p < 2; p++) begin
                key_d[p] = (key_q[p] & ~hit[p]) | (hit[p] & {KEY_SET_W{ps2_key[9]}});
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-player merge, SOCD and coin stretch
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS*4-1:0]       dir_d, dir_q;
    logic [NUM_PLAYERS*NUM_BTN-1:0] btn_d, btn_q;
    logic [NUM_PLAYERS-1:0]         start_d, start_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam int unsigned BASE = p * JOY_W;

        key_set_t   k;
        logic [3:0] d_raw;

        if (p < 2) begin : g_keys
            assign k = key_q[p];
        end else begin : g_nokeys
            assign k = '0;
        end

        assign d_raw = joy[BASE +: 4] | k.dir;

        assign dir_d[p*4 + JB_U] = d_raw[JB_U] & ~(SOCD & d_raw[JB_D]);
        assign dir_d[p*4 + JB_D] = d_raw[JB_D] & ~(SOCD & d_raw[JB_U]);
        assign dir_d[p*4 + JB_L] = d_raw[JB_L] & ~(SOCD & d_raw[JB_R]);
        assign dir_d[p*4 + JB_R] = d_raw[JB_R] & ~(SOCD & d_raw[JB_L]);

        for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
            if (b < 4) begin : g_kb
                assign btn_d[p*NUM_BTN + b] = joy[BASE + JB_BTN0 + b] | k.btn[b];
            end else begin : g_jb
                assign btn_d[p*NUM_BTN + b] = joy[BASE + JB_BTN0 + b];
            end
        end

        assign start_d[p] = joy[BASE + JB_BTN0 + NUM_BTN] | k.start;

        coin_stretch #(
            .HOLD (COIN_HOLD)
        ) u_coin (
            .CLK   (CLK),
            .RESET (RESET),
            .raw   (joy[BASE + JB_BTN0 + NUM_BTN + 1] | k.coin),
            .out   (coin[p])
        );
    end

    // The toggle copy follows ps2_key[10] even in reset, so an event that
    // lands during reset is absorbed rather than replayed afterwards.
    always_ff @(posedge CLK) begin
        tog_q <= ps2_key[10];
        if (RESET) begin
            key_q   <= '0;
            dir_q   <= '0;
            btn_q   <= '0;
            start_q <= '0;
        end else begin
            key_q   <= key_d;
            dir_q   <= dir_d;
            btn_q   <= btn_d;
            start_q <= start_d;
        end
    end

    assign dir   = dir_q;
    assign btn   = btn_q;
    assign start = start_q;

    // ------------------------------------------------------------------
    // DIP capture. No reset: the top folds ioctl_download into RESET, so a
    // reset here would wipe the bytes just loaded. Power-up value comes from
    // FPGA configuration (all zero).
    // ------------------------------------------------------------------
    logic [DIP_BANKS-1:0][7:0] dip_q;
    logic                      dip_wr;

    assign dip_wr = ioctl_wr && (ioctl_index == IOCTL_DIP);

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < DIP_BANKS; i++) begin
            if (dip_wr && ioctl_addr == 25'(i)) dip_q[i] <= ioctl_dout;
        end
    end

    assign dipsw = dip_q;

    // Joystick bits beyond start/coin are not part of the control set.
    logic unused_joy;
    assign unused_joy = ^joy;

endmodule
